// File: rtl/reg_exec_stage.sv
// Two-stage register/execute slice: a 16x16 register file feeding a small ALU.
// E stage latches the operands (with forwarding from the retiring instruction),
// W stage registers the ALU result, writes it back and updates the flags.
module reg_exec_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  read_reg_1,
  input  logic [3:0]  read_reg_2,
  input  logic [3:0]  write_reg,
  input  logic [3:0]  op,
  output logic [15:0] result,
  output logic        result_valid,
  output logic [3:0]  wb_reg,
  output logic        zero,
  output logic        carry,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8;
  localparam logic [3:0] OP_LI  = 4'd9;

  logic [15:0] rf_q [16];

  logic [3:0]  e_op_q, e_wr_q, e_r1_q, e_r2_q;
  logic [15:0] e_a_q, e_b_q;
  logic [15:0] a_d, b_d;

  logic [15:0] result_q;
  logic        result_valid_q;
  logic [3:0]  wb_reg_q;
  logic        zero_q, carry_q;

  logic [16:0] sum17, diff17;
  logic [15:0] alu_res;
  logic        alu_carry;
  logic        e_live;
  logic        fwd_a, fwd_b;

  // Opcodes 10-15 behave exactly like NOP, so "live" means 1..9.
  assign e_live = (e_op_q >= OP_ADD) && (e_op_q <= OP_LI);

  assign sum17  = {1'b0, e_a_q} + {1'b0, e_b_q};
  assign diff17 = {1'b0, e_a_q} - {1'b0, e_b_q};

  // ALU on the E-stage latched operands; carry is bit 16 of the wide add/sub.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (e_op_q)
      OP_ADD: begin alu_res = sum17[15:0];  alu_carry = sum17[16];  end
      OP_SUB: begin alu_res = diff17[15:0]; alu_carry = diff17[16]; end
      OP_AND: alu_res = e_a_q & e_b_q;
      OP_OR:  alu_res = e_a_q | e_b_q;
      OP_XOR: alu_res = e_a_q ^ e_b_q;
      OP_SLL: alu_res = e_a_q << e_b_q[3:0];
      OP_SRL: alu_res = e_a_q >> e_b_q[3:0];
      OP_SLT: alu_res = {15'd0, (e_a_q < e_b_q)};
      OP_LI:  alu_res = {8'h00, e_r1_q, e_r2_q};
      default: alu_res = '0;
    endcase
  end

  // Operand select: bypass the result being written this edge, R0 always reads 0.
  assign fwd_a = e_live && (e_wr_q != 4'd0) && (e_wr_q == read_reg_1);
  assign fwd_b = e_live && (e_wr_q != 4'd0) && (e_wr_q == read_reg_2);

  always_comb begin
    a_d = (read_reg_1 == 4'd0) ? 16'h0000 : rf_q[read_reg_1];
    b_d = (read_reg_2 == 4'd0) ? 16'h0000 : rf_q[read_reg_2];
    if (fwd_a) a_d = alu_res;
    if (fwd_b) b_d = alu_res;
  end

  // E stage: capture the incoming instruction and its operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_op_q <= OP_NOP;
      e_wr_q <= '0;
      e_r1_q <= '0;
      e_r2_q <= '0;
      e_a_q  <= '0;
      e_b_q  <= '0;
    end else begin
      e_op_q <= op;
      e_wr_q <= write_reg;
      e_r1_q <= read_reg_1;
      e_r2_q <= read_reg_2;
      e_a_q  <= a_d;
      e_b_q  <= b_d;
    end
  end

  // W stage: retire live instructions into result/flags; NOPs leave them held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
      wb_reg_q       <= '0;
      zero_q         <= 1'b0;
      carry_q        <= 1'b0;
    end else begin
      result_valid_q <= e_live;
      if (e_live) begin
        result_q <= alu_res;
        wb_reg_q <= e_wr_q;
        zero_q   <= (alu_res == 16'h0000);
        if (e_op_q == OP_ADD || e_op_q == OP_SUB) carry_q <= alu_carry;
      end
    end
  end

  // Register file write-back; writes to R0 are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else if (e_live && (e_wr_q != 4'd0)) begin
      rf_q[e_wr_q] <= alu_res;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign wb_reg       = wb_reg_q;
  assign zero         = zero_q;
  assign carry        = carry_q;
  // Debug port reads the array directly, so a same-edge write shows up only after the edge.
  assign dbg_data     = (dbg_addr == 4'd0) ? 16'h0000 : rf_q[dbg_addr];

endmodule

// File: tb/tb_reg_exec_stage.sv
// Directed bench for reg_exec_stage: hand-computed results checked as each
// instruction retires one cycle after it is issued.
module tb_reg_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  read_reg_1 = '0, read_reg_2 = '0, write_reg = '0, op = '0;
  logic [15:0] result;
  logic        result_valid;
  logic [3:0]  wb_reg;
  logic        zero, carry;
  logic [3:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int n_chk = 0;
  int n_bad = 0;

  reg_exec_stage dut (
    .clk(clk), .rst(rst),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .write_reg(write_reg), .op(op),
    .result(result), .result_valid(result_valid), .wb_reg(wb_reg),
    .zero(zero), .carry(carry),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one instruction on the next rising edge; return 1 time unit after it.
  task automatic step(input logic [3:0] o, input logic [3:0] r1, input logic [3:0] r2,
                      input logic [3:0] wr);
    @(negedge clk);
    op = o; read_reg_1 = r1; read_reg_2 = r2; write_reg = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic retired(input string tag, input logic [15:0] exp_res, input logic [3:0] exp_wb);
    chk({tag, ".res"}, {16'd0, result}, {16'd0, exp_res});
    chk({tag, ".vld"}, {31'd0, result_valid}, 32'd1);
    chk({tag, ".wb"}, {28'd0, wb_reg}, {28'd0, exp_wb});
  endtask

  task automatic dbg(input string tag, input logic [3:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, {16'd0, dbg_data}, {16'd0, exp});
  endtask

  initial begin
    // Come out of power-on reset, run a few instructions, then reset mid-stream.
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    step(4'd9, 4'h3, 4'hC, 4'd7);   // LI R7 = 0x3C
    step(4'd0, 4'd0, 4'd0, 4'd0);   // R7 written here
    step(4'd9, 4'h1, 4'h1, 4'd8);   // LI R8 = 0x11 in flight
    chk("pre_rst.r7_res", {16'd0, result}, 32'h003C);
    rst = 1'b0;
    op = 4'd0;
    #1;
    chk("rst.res", {16'd0, result}, 32'h0);
    chk("rst.vld", {31'd0, result_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rst.zero", {31'd0, zero}, 32'd0);
    chk("rst.carry", {31'd0, carry}, 32'd0);
    for (int i = 0; i < 16; i++) dbg($sformatf("rst.dbg%0d", i), i[3:0], 16'h0000);
    step(4'd0, 4'd0, 4'd0, 4'd0);
    dbg("rst.r8_discarded", 4'd8, 16'h0000);
    chk("rst.first_vld", {31'd0, result_valid}, 32'd0);

    // LI then dependent ADD via forwarding.
    step(4'd9, 4'd1, 4'd2, 4'd1);   // LI R1 = 0x12
    step(4'd1, 4'd1, 4'd1, 4'd2);   // ADD R2 = R1 + R1
    retired("li_r1", 16'h0012, 4'd1);
    step(4'd0, 4'd0, 4'd0, 4'd0);
    retired("add_r2", 16'h0024, 4'd2);
    dbg("dbg_r2", 4'd2, 16'h0024);
    step(4'd0, 4'd0, 4'd0, 4'd0);
    chk("nop.vld", {31'd0, result_valid}, 32'd0);
    chk("nop.res_hold", {16'd0, result}, 32'h0024);

    // Carry and zero.
    step(4'd9, 4'hF, 4'hF, 4'd3);   // LI R3 = 0xFF
    step(4'd9, 4'h0, 4'h8, 4'd4);   // LI R4 = 8
    retired("li_r3", 16'h00FF, 4'd3);
    step(4'd6, 4'd3, 4'd4, 4'd3);   // SLL R3 = R3 << R4
    retired("li_r4", 16'h0008, 4'd4);
    step(4'd1, 4'd3, 4'd3, 4'd5);   // ADD R5 = R3 + R3
    retired("sll_r3", 16'hFF00, 4'd3);
    step(4'd2, 4'd5, 4'd5, 4'd6);   // SUB R6 = R5 - R5
    retired("add_r5", 16'hFE00, 4'd5);
    chk("add_r5.carry", {31'd0, carry}, 32'd1);
    chk("add_r5.zero", {31'd0, zero}, 32'd0);
    step(4'd0, 4'd0, 4'd0, 4'd0);
    retired("sub_r6", 16'h0000, 4'd6);
    chk("sub_r6.zero", {31'd0, zero}, 32'd1);
    chk("sub_r6.carry", {31'd0, carry}, 32'd0);
    dbg("dbg_r3", 4'd3, 16'hFF00);

    // NOP hold, including an undefined opcode with a nonzero destination.
    step(4'd11, 4'd3, 4'd3, 4'd7);
    chk("nop0.vld", {31'd0, result_valid}, 32'd0);
    step(4'd0, 4'd0, 4'd0, 4'd0);
    chk("nop11.vld", {31'd0, result_valid}, 32'd0);
    chk("nop11.res", {16'd0, result}, 32'h0000);
    chk("nop11.wb", {28'd0, wb_reg}, 32'd6);
    chk("nop11.zero", {31'd0, zero}, 32'd1);
    chk("nop11.carry", {31'd0, carry}, 32'd0);
    dbg("nop11.r7", 4'd7, 16'h0000);
    dbg("nop11.r5", 4'd5, 16'hFE00);

    // R0 protection.
    step(4'd9, 4'h5, 4'h5, 4'd0);   // LI R0 = 0x55 (dropped)
    step(4'd1, 4'd0, 4'd5, 4'd8);   // ADD R8 = R0 + R5, no forward from R0
    retired("li_r0", 16'h0055, 4'd0);
    dbg("dbg_r0", 4'd0, 16'h0000);
    step(4'd0, 4'd0, 4'd0, 4'd0);
    retired("add_r8", 16'hFE00, 4'd8);
    chk("add_r8.carry", {31'd0, carry}, 32'd0);

    // Shift / SLT boundaries and logic ops.
    step(4'd9, 4'h8, 4'h0, 4'd9);   // LI R9 = 0x80
    step(4'd9, 4'h0, 4'h8, 4'd10);  // LI R10 = 8
    retired("li_r9", 16'h0080, 4'd9);
    step(4'd6, 4'd9, 4'd10, 4'd9);  // SLL R9 = 0x8000
    retired("li_r10", 16'h0008, 4'd10);
    step(4'd9, 4'h0, 4'hF, 4'd11);  // LI R11 = 15
    retired("sll_r9", 16'h8000, 4'd9);
    step(4'd7, 4'd9, 4'd11, 4'd12); // SRL R12 = 0x8000 >> 15
    retired("li_r11", 16'h000F, 4'd11);
    step(4'd6, 4'd9, 4'd0, 4'd13);  // SLL R13 = R9 << 0
    retired("srl15", 16'h0001, 4'd12);
    step(4'd9, 4'h0, 4'h5, 4'd14);  // LI R14 = 5
    retired("sll0", 16'h8000, 4'd13);
    step(4'd9, 4'h0, 4'h4, 4'd15);  // LI R15 = 4
    retired("li_r14", 16'h0005, 4'd14);
    step(4'd8, 4'd14, 4'd14, 4'd1); // SLT 5 < 5
    retired("li_r15", 16'h0004, 4'd15);
    step(4'd8, 4'd15, 4'd14, 4'd2); // SLT 4 < 5
    retired("slt_eq", 16'h0000, 4'd1);
    chk("slt_eq.zero", {31'd0, zero}, 32'd1);
    step(4'd5, 4'd9, 4'd14, 4'd3);  // XOR
    retired("slt_lt", 16'h0001, 4'd2);
    chk("slt_lt.zero", {31'd0, zero}, 32'd0);
    step(4'd3, 4'd9, 4'd10, 4'd4);  // AND
    retired("xor", 16'h8005, 4'd3);
    step(4'd4, 4'd9, 4'd14, 4'd5);  // OR
    retired("and", 16'h0000, 4'd4);
    step(4'd0, 4'd0, 4'd0, 4'd0);
    retired("or", 16'h8005, 4'd5);
    dbg("dbg_r12", 4'd12, 16'h0001);
    dbg("dbg_r13", 4'd13, 16'h8000);
    dbg("dbg_r1", 4'd1, 16'h0000);
    dbg("dbg_r2b", 4'd2, 16'h0001);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_exec_stage.md
REG_EXEC_STAGE -- requirements
Module: reg_exec_stage

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port read_reg_1  input  4  source register A index, or immediate high nibble for LI; driven by the decoder.
REQ-004 SHALL have port read_reg_2  input  4  source register B index, or immediate low nibble for LI.
REQ-005 SHALL have port write_reg  input  4  destination register index.
REQ-006 SHALL have port op  input  4  operation code.
REQ-007 SHALL have port result  output  16  registered ALU result of the last retired instruction.
REQ-008 SHALL have port result_valid  output  1  high for exactly one cycle per retired non-NOP instruction.
REQ-009 SHALL have port wb_reg  output  4  destination index of the instruction reported on result.
REQ-010 SHALL have port zero  output  1  set when the last retired ALU result == 16'h0000.
REQ-011 SHALL have port carry  output  1  ADD carry-out / SUB borrow of the last ADD or SUB.
REQ-012 SHALL have port dbg_addr  input  4  debug read index.
REQ-013 SHALL have port dbg_data  output  16  combinational read of regfile[dbg_addr]; always 0 for index 0.

Function
REQ-014 SHALL contain 16 x 16-bit registers; R0 reads as 0 and ignores writes.
REQ-015 SHALL decode op as follows:
- 0 = NOP
- 1 = ADD A+B
- 2 = SUB A-B
- 3 = AND
- 4 = OR
- 5 = XOR
- 6 = SLL A<<B[3:0]
- 7 = SRL A>>B[3:0] (logical)
- 8 = SLT (unsigned A<B -> 1, else 0)
- 9 = LI {8'h00, read_reg_1, read_reg_2}
- 10-15 = NOP
REQ-016 SHALL be two-stage:
- E stage: on edge N, capture op, write_reg and operands A = reg[read_reg_1], B = reg[read_reg_2].
- W stage: on edge N+1, register the ALU output into result, write it to reg[write_reg], and assert result_valid for the following cycle.
REQ-017 SHALL forward the combinational ALU output into the E-stage operand capture when the W-stage instruction is non-NOP, its write_reg is nonzero, and it equals read_reg_1 or read_reg_2, so back-to-back dependent instructions see the new value.
REQ-018 SHALL never write the register file, update flags, or pulse result_valid for a NOP; result and wb_reg SHALL hold their previous values on a NOP.
REQ-019 SHALL update zero on every non-NOP instruction and update carry only on ADD and SUB.
REQ-020 SHALL compute all arithmetic modulo 2^16, with carry taken as bit 16 of the 17-bit sum or difference.
REQ-021 SHALL still report result, wb_reg and result_valid for an instruction with write_reg = 0, with the register file left unchanged.
REQ-022 SHALL let a dbg_addr read of a register being written on edge N+1 return the new value only after that edge (no bypass on the debug port).

Reset
REQ-023 SHALL, while rst is low, asynchronously clear:
- all 16 registers
- the E-stage pipeline register (op forced to NOP)
- result, result_valid, wb_reg, zero and carry
REQ-024 SHALL discard any instruction in flight at reset assertion, with no register write.
REQ-025 SHALL treat the first rising edge after rst deasserts as a normal E-stage capture.

Verification
REQ-026 Reset: drive rst low mid-stream, then release -> result=0, result_valid=0, zero=0, carry=0, and dbg_data=0 for all indices.
REQ-027 LI then ADD: LI R1=0x12 (op 9, r1=1, r2=2, wr=1), then ADD R2=R1+R1 on the next cycle -> second result=0x0024 via forwarding, result_valid high two consecutive cycles, dbg R2=0x0024.
REQ-028 Carry and zero:
- R3=0xFF, R3=R3 SLL 8 (R4=8) gives R3=0xFF00.
- R5 = R3 + R3 -> result=0xFE00, carry=1, zero=0.
- R6 = R5 SUB R5 -> result=0x0000, zero=1, carry=0.
REQ-029 R0 protection: LI with wr=0 and immediate 0x55 -> result=0x0055 and result_valid=1, but dbg_data at 0 stays 0; a subsequent ADD using R0 reads 0.
REQ-030 NOP hold: ops 0 and 11 inserted between instructions -> result_valid=0, result and flags unchanged, no register modified.
REQ-031 Shift and SLT boundaries:
- SRL 0x8000 by 15 -> 0x0001.
- SLL by 0 -> operand unchanged.
- SLT 5<5 -> 0, 4<5 -> 1.
